can_rx_frame_buffer: RTL
========================

# can_rx_frame_buffer

Downstream consumer of `can_top`'s receive byte stream. Collects the per-byte `rx_valid`/`rx_last`/`rx_data` stream into whole frames (ID, IDE, length, up to 8 data bytes). Queues completed frames in a small FIFO. Presents them to the host logic over a valid/ready handshake, one frame per transfer. Frames that arrive while the FIFO is full are dropped and counted.

## Interface
- `DEPTH_LOG2`, default 2: FIFO holds 2^DEPTH_LOG2 frames (range 1..6).
- `rstn`  in  1: asynchronous reset, active-low.
- `clk`  in  1: single clock, same clock as `can_top`.
- `rx_valid`  in  1: data byte valid, from `can_top`.
- `rx_last`  in  1: qualifies the last byte of a frame (meaningful only with `rx_valid`).
- `rx_data`  in  8: received data byte.
- `rx_id`  in  29: frame ID. Sampled on the last byte. Short IDs are in [10:0].
- `rx_ide`  in  1: 1 = extended (29-bit) ID, 0 = standard (11-bit). Sampled on the last byte.
- `frm_valid`  out  1: a frame is available at the output.
- `frm_ready`  in  1: consumer accepts the frame.
- `frm_id`  out  29: ID of the head frame.
- `frm_ide`  out  1: IDE of the head frame.
- `frm_len`  out  4: byte count of the head frame, 1..8.
- `frm_data`  out  64: payload. Byte k is at [8k+7:8k]. Unused bytes are 0.
- `frm_count`  out  DEPTH_LOG2+1: number of frames currently queued.
- `drop_cnt`  out  16: frames dropped because the FIFO was full. Saturates at 16'hFFFF.

## Operation
- Assembly state is `asm_len` (0..8) and `asm_data` (64 b).
  - Each `rx_valid` with `asm_len`<8 writes `rx_data` into byte lane `asm_len` and increments `asm_len`.
  - Bytes arriving when `asm_len`==8 are discarded. The length stays 8.
- Commit happens on `rx_valid & rx_last`.
  - The entry is {`rx_ide`, `rx_id`, final length, payload including the current byte}.
  - The same cycle, `asm_len` returns to 0 and `asm_data` returns to 0.
  - The assembler is ready for the next frame's first byte in the very next cycle.
- Push is accepted when `frm_count` < depth, or when the FIFO is full and a pop occurs in the same cycle.
  - Otherwise the frame is discarded and `drop_cnt` increments (saturating).
  - The assembly state is cleared in either case.
- Pop happens on `frm_valid & frm_ready`. `frm_ready` without `frm_valid` is ignored.
- Output fields are driven from the FIFO head. They hold stable while `frm_valid` is high and `frm_ready` is low.
- `rx_valid` bytes need not be consecutive. Any number of idle cycles between bytes is legal.
- `rx_id`/`rx_ide` are ignored except on the commit cycle.

## Timing
- Reset values:
  - `frm_valid`=0, `frm_count`=0, `drop_cnt`=0.
  - `frm_id`=0, `frm_ide`=0, `frm_len`=0, `frm_data`=0.
  - Assembly state cleared.
- Reset asserted mid-frame discards the partial frame and all queued frames.
- Latency: commit at edge N gives `frm_valid`=1 after edge N+1 when the FIFO was empty. This is a 1-cycle registered push-to-visible latency.
- Pop at edge M exposes the next head after edge M with no bubble. It also updates `frm_count`.
- Simultaneous push and pop:
  - `frm_count` is unchanged.
  - On a non-empty FIFO the pushed frame goes to the tail.
  - On an empty FIFO the pop cannot occur, because `frm_valid` is 0.
- Read and write pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Full/empty are derived from `frm_count`. It never exceeds 2^DEPTH_LOG2.
- No combinational path from `frm_ready` to any output. No combinational path from `rx_*` to any output.

## Structure
- Shared package constants:
  - `CAN_MAX_BYTES`=8.
  - Frame entry width = 1+29+4+64 = 98 bits.
  - Field offsets within the entry: ide, id, len, data.
- One sub-module: `can_frame_fifo`. It is a parameterised synchronous FIFO (width, DEPTH_LOG2) with count, full/empty and show-ahead head output.
- The top handles assembly, the commit decision and the drop counter.

## Test plan
- Standard frame: bytes 11,22,33 with last on 33, `rx_id`=0x003, `rx_ide`=0.
  - Response: `frm_valid`, `frm_len`=3, `frm_data`=0x332211, `frm_id`=0x003, `frm_ide`=0.
- Extended frame: 8 bytes 01..08, `rx_id`=0x12345678, `rx_ide`=1, with idle gaps of 0–5 cycles between bytes.
  - Response: `frm_len`=8, `frm_data`=0x0807060504030201, `frm_ide`=1.
- Overlong frame: 10 bytes 01..0A.
  - Response: `frm_len`=8, payload = bytes 01..08, `drop_cnt`=0.
- Overflow at DEPTH_LOG2=2 with `frm_ready`=0: push 6 frames.
  - Response: `frm_count`=4, `drop_cnt`=2, and the first 4 frames pop in order.
- Full FIFO with a commit and `frm_ready`=1 in the same cycle.
  - Response: frame accepted, `frm_count` stays 4, `drop_cnt` unchanged.
- Reset asserted after 3 bytes of a frame with 2 frames queued.
  - Response: `frm_valid`=0, `frm_count`=0, and the next full frame is received intact.

Source files
------------

// File: rtl/can_rx_frame_buffer_pkg.sv
//------------------------------------------------------------------------------
// Module   : can_rx_frame_buffer_pkg
// Brief    : Shared constants and frame entry layout for the CAN RX frame buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package can_rx_frame_buffer_pkg;

  localparam int CAN_MAX_BYTES = 8;
  localparam int CAN_ID_W      = 29;
  localparam int CAN_LEN_W     = 4;
  localparam int CAN_DATA_W    = 8 * CAN_MAX_BYTES;
  localparam int FRAME_W       = 1 + CAN_ID_W + CAN_LEN_W + CAN_DATA_W;

  localparam int DATA_LSB = 0;
  localparam int LEN_LSB  = DATA_LSB + CAN_DATA_W;
  localparam int ID_LSB   = LEN_LSB + CAN_LEN_W;
  localparam int IDE_LSB  = ID_LSB + CAN_ID_W;

  // Member order matches the offsets above: ide is the MSB, data the LSBs.
  typedef struct packed {
    logic                  ide;
    logic [CAN_ID_W-1:0]   id;
    logic [CAN_LEN_W-1:0]  len;
    logic [CAN_DATA_W-1:0] data;
  } frame_t;

endpackage

`default_nettype wire

// File: rtl/can_frame_fifo.sv
//------------------------------------------------------------------------------
// Module   : can_frame_fifo
// Brief    : Show-ahead synchronous FIFO with occupancy count; accepts a push
//            into a full FIFO when a pop happens on the same edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module can_frame_fifo #(
  parameter int WIDTH      = 98,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic                  push_ok_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic [WIDTH-1:0]      head_o
);

  localparam int                DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;

  assign full      = (count_q == DEPTH_C);
  assign empty_o   = (count_q == '0);
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full | do_pop);
  assign push_ok_o = do_push;
  assign count_o   = count_q;
  // Gate the head so an empty FIFO presents zeros instead of stale storage.
  assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/can_rx_frame_buffer.sv
//------------------------------------------------------------------------------
// Module   : can_rx_frame_buffer
// Brief    : Assembles the CAN RX byte stream into frames, queues them and
//            hands them to the host over valid/ready; counts dropped frames.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module can_rx_frame_buffer
  import can_rx_frame_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_valid,
  input  logic                  rx_last,
  input  logic [7:0]            rx_data,
  input  logic [CAN_ID_W-1:0]   rx_id,
  input  logic                  rx_ide,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [CAN_ID_W-1:0]   frm_id,
  output logic                  frm_ide,
  output logic [CAN_LEN_W-1:0]  frm_len,
  output logic [CAN_DATA_W-1:0] frm_data,
  output logic [DEPTH_LOG2:0]   frm_count,
  output logic [15:0]           drop_cnt
);

  logic [CAN_LEN_W-1:0]  asm_len_q,  asm_len_d;
  logic [CAN_DATA_W-1:0] asm_data_q, asm_data_d;
  logic                  pend_vld_q, pend_vld_d;
  frame_t                pend_q,     pend_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic [CAN_LEN_W-1:0]  lane_len;
  logic [CAN_DATA_W-1:0] lane_data;
  logic                  push_ok;
  logic                  fifo_empty;
  logic [FRAME_W-1:0]    fifo_head;
  frame_t                head;

  always_comb begin
    lane_len  = asm_len_q;
    lane_data = asm_data_q;
    if (asm_len_q < CAN_LEN_W'(CAN_MAX_BYTES)) begin
      lane_data[{asm_len_q[2:0], 3'b000} +: 8] = rx_data;
      lane_len = asm_len_q + 4'd1;
    end

    asm_len_d  = asm_len_q;
    asm_data_d = asm_data_q;
    pend_vld_d = 1'b0;
    pend_d     = pend_q;
    if (rx_valid) begin
      if (rx_last) begin
        asm_len_d   = '0;
        asm_data_d  = '0;
        pend_vld_d  = 1'b1;
        pend_d.ide  = rx_ide;
        pend_d.id   = rx_id;
        pend_d.len  = lane_len;
        pend_d.data = lane_data;
      end else begin
        asm_len_d  = lane_len;
        asm_data_d = lane_data;
      end
    end

    // A committed frame the FIFO cannot take is lost; count it, saturating.
    drop_cnt_d = drop_cnt_q;
    if (pend_vld_q && !push_ok && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      asm_len_q  <= '0;
      asm_data_q <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      asm_len_q  <= asm_len_d;
      asm_data_q <= asm_data_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  can_frame_fifo #(
    .WIDTH      (FRAME_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push_i    (pend_vld_q),
    .data_i    (pend_q),
    .pop_i     (frm_ready),
    .push_ok_o (push_ok),
    .empty_o   (fifo_empty),
    .count_o   (frm_count),
    .head_o    (fifo_head)
  );

  assign head      = fifo_head;
  assign frm_valid = ~fifo_empty;
  assign frm_id    = head.id;
  assign frm_ide   = head.ide;
  assign frm_len   = head.len;
  assign frm_data  = head.data;
  assign drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire
